pwm_generator: RTL and testbench

//  Per-transducer PWM output stage fed by pwm_preconditioner (OVER/LEFT/RIGHT) plus CYCLE.

---
 rtl/pwm_generator_if.sv | 36 +++
 rtl/pwm_generator.sv | 94 +++++++++
 tb/tb_pwm_generator.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_generator_if.sv
// Control/data bundle between the preconditioner side (master) and pwm_generator (slave).
// FORCE_OFF is only present when PWM_FORCE_OFF_EN is defined.
interface pwm_generator_if #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 249
);
    logic                        SYNC;
    logic                        LOAD;
    logic [DEPTH-1:0][WIDTH-1:0] CYCLE;
    logic [DEPTH-1:0]            OVER;
    logic [DEPTH-1:0][WIDTH-1:0] LEFT;
    logic [DEPTH-1:0][WIDTH-1:0] RIGHT;
    logic [DEPTH-1:0]            PWM_OUT;
    logic                        BUSY;
`ifdef PWM_FORCE_OFF_EN
    logic                        FORCE_OFF;

    modport master (
        output SYNC, LOAD, CYCLE, OVER, LEFT, RIGHT, FORCE_OFF,
        input  PWM_OUT, BUSY
    );
    modport slave (
        input  SYNC, LOAD, CYCLE, OVER, LEFT, RIGHT, FORCE_OFF,
        output PWM_OUT, BUSY
    );
`else
    modport master (
        output SYNC, LOAD, CYCLE, OVER, LEFT, RIGHT,
        input  PWM_OUT, BUSY
    );
    modport slave (
        input  SYNC, LOAD, CYCLE, OVER, LEFT, RIGHT,
        output PWM_OUT, BUSY
    );
`endif
endinterface

// File: rtl/pwm_generator.sv
// Per-channel PWM output stage with double-buffered edges applied at each channel's wrap.
// Optional PWM_FORCE_OFF_EN adds FORCE_OFF, which blanks PWM_OUT while counters keep running.
module pwm_generator #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 249
) (
    input logic           CLK,
    input logic           RST,
    pwm_generator_if.slave bus
);
    typedef struct packed {
        logic [WIDTH-1:0] cyc;
        logic             over;
        logic [WIDTH-1:0] left;
        logic [WIDTH-1:0] right;
    } cfg_t;

    logic [DEPTH-1:0] pend_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ch
        logic [WIDTH-1:0] t_q, t_d;
        cfg_t             act_q, act_d;
        cfg_t             pend_q, pend_d;
        cfg_t             load_cfg;
        logic             pvalid_q, pvalid_d;
        logic             pwm_q, pwm_d;
        logic             wrap;
        logic             hit;

        assign load_cfg.cyc   = bus.CYCLE[i];
        assign load_cfg.over  = bus.OVER[i];
        assign load_cfg.left  = bus.LEFT[i];
        assign load_cfg.right = bus.RIGHT[i];

        // Periods below 2 hold the counter at 0, so every cycle counts as a boundary.
        assign wrap = (act_q.cyc < WIDTH'(2)) || (t_q == act_q.cyc - WIDTH'(1));

        assign hit = act_q.over ? ((t_q >= act_q.left) || (t_q < act_q.right))
                                : ((t_q >= act_q.left) && (t_q < act_q.right));

        always_comb begin
            act_d    = act_q;
            pend_d   = pend_q;
            pvalid_d = pvalid_q;
            t_d      = wrap ? '0 : t_q + WIDTH'(1);
            if (bus.SYNC) begin
                t_d = '0;
                if (bus.LOAD) begin
                    act_d    = load_cfg;
                    pvalid_d = 1'b0;
                end else if (pvalid_q) begin
                    act_d    = pend_q;
                    pvalid_d = 1'b0;
                end
            end else begin
                if (wrap && pvalid_q) begin
                    act_d    = pend_q;
                    pvalid_d = 1'b0;
                end
                // A LOAD landing on a wrap is held for the following boundary.
                if (bus.LOAD) begin
                    pend_d   = load_cfg;
                    pvalid_d = 1'b1;
                end
            end
`ifdef PWM_FORCE_OFF_EN
            pwm_d = hit & ~bus.FORCE_OFF;
`else
            pwm_d = hit;
`endif
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                t_q      <= '0;
                act_q    <= '0;
                pend_q   <= '0;
                pvalid_q <= 1'b0;
                pwm_q    <= 1'b0;
            end else begin
                t_q      <= t_d;
                act_q    <= act_d;
                pend_q   <= pend_d;
                pvalid_q <= pvalid_d;
                pwm_q    <= pwm_d;
            end
        end

        assign pend_valid[i]  = pvalid_q;
        assign bus.PWM_OUT[i] = pwm_q;
    end

    assign bus.BUSY = |pend_valid;
endmodule

// File: tb/tb_pwm_generator.sv
// Scoreboard bench for pwm_generator on a 4-channel instance.
// Defining PWM_FORCE_OFF_EN also runs the FORCE_OFF scenario.
module tb_pwm_generator;
    localparam int unsigned W = 13;
    localparam int unsigned N = 4;

    typedef struct packed {
        logic [W-1:0] cyc;
        logic         over;
        logic [W-1:0] left;
        logic [W-1:0] right;
    } cfg_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    pwm_generator_if #(.WIDTH(W), .DEPTH(N)) bus ();

    pwm_generator #(.WIDTH(W), .DEPTH(N)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] exp_pwm_q[$];
    logic         exp_busy_q[$];
    cfg_t         drv[N];

    function automatic logic hit(input cfg_t c, input int j);
        int t;
        t = (c.cyc < 2) ? 0 : j % int'(c.cyc);
        if (c.over) return (t >= int'(c.left)) || (t < int'(c.right));
        return (t >= int'(c.left)) && (t < int'(c.right));
    endfunction

    task automatic drive_cfg();
        for (int i = 0; i < N; i++) begin
            bus.CYCLE[i] = drv[i].cyc;
            bus.OVER[i]  = drv[i].over;
            bus.LEFT[i]  = drv[i].left;
            bus.RIGHT[i] = drv[i].right;
        end
    endtask

    // SYNC+LOAD realigns all channels; the first cycle after return has t=0.
    task automatic sync_load();
        drive_cfg();
        bus.SYNC = 1'b1;
        bus.LOAD = 1'b1;
        @(posedge CLK); #1;
        bus.SYNC = 1'b0;
        bus.LOAD = 1'b0;
    endtask

    task automatic test_reset();
        logic [N-1:0] got;
        RST = 1'b1;
        drv[0] = '{cyc: 10, over: 1'b1, left: 2, right: 7};
        for (int i = 1; i < N; i++) drv[i] = drv[0];
        drive_cfg();
        for (int k = 0; k < 3; k++) begin
            bus.SYNC = 1'b1;
            bus.LOAD = k[0] ? 1'b0 : 1'b1;
            @(posedge CLK); #1;
            got = bus.PWM_OUT;
            checks++;
            if (got !== '0) begin
                failures++;
                $display("FAIL reset_pwm k=%0d got=%b exp=0", k, got);
            end
        end
        RST = 1'b0;
        bus.SYNC = 1'b0;
        bus.LOAD = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK); #1;
            checks++;
            if (bus.PWM_OUT !== '0 || bus.BUSY !== 1'b0) begin
                failures++;
                $display("FAIL reset_release k=%0d pwm=%b busy=%b exp pwm=0 busy=0",
                         k, bus.PWM_OUT, bus.BUSY);
            end
        end
    endtask

    task automatic test_basic();
        logic [N-1:0] e, got;
        logic         eb;
        drv[0] = '{cyc: 10, over: 1'b0, left: 3, right: 7};
        drv[1] = '{cyc: 10, over: 1'b1, left: 8, right: 2};
        drv[2] = '{cyc: 10, over: 1'b0, left: 5, right: 5};
        drv[3] = '{cyc: 1,  over: 1'b0, left: 5, right: 5};
        sync_load();
        for (int j = 0; j < 25; j++) begin
            for (int i = 0; i < N; i++) e[i] = hit(drv[i], j);
            exp_pwm_q.push_back(e);
            exp_busy_q.push_back(1'b0);
            @(posedge CLK); #1;
            e   = exp_pwm_q.pop_front();
            eb  = exp_busy_q.pop_front();
            got = bus.PWM_OUT;
            checks++;
            if (got !== e || bus.BUSY !== eb) begin
                failures++;
                $display("FAIL basic j=%0d pwm got=%b exp=%b busy got=%b exp=%b",
                         j, got, e, bus.BUSY, eb);
            end
        end
    endtask

    task automatic test_pending();
        cfg_t         oldc[N];
        cfg_t         newc[N];
        logic [N-1:0] e, got;
        logic         eb;
        sync_load();
        for (int i = 0; i < N; i++) oldc[i] = drv[i];
        newc = oldc;
        newc[0].left  = 0;
        newc[0].right = 5;
        for (int j = 0; j < 25; j++) begin
            for (int i = 0; i < N; i++) e[i] = (j >= 10) ? hit(newc[i], j) : hit(oldc[i], j);
            exp_pwm_q.push_back(e);
            exp_busy_q.push_back(j >= 4 && j <= 8);
            if (j == 4) begin
                drv = newc;
                drive_cfg();
                bus.LOAD = 1'b1;
            end
            @(posedge CLK); #1;
            bus.LOAD = 1'b0;
            e   = exp_pwm_q.pop_front();
            eb  = exp_busy_q.pop_front();
            got = bus.PWM_OUT;
            checks++;
            if (got !== e || bus.BUSY !== eb) begin
                failures++;
                $display("FAIL pending j=%0d pwm got=%b exp=%b busy got=%b exp=%b",
                         j, got, e, bus.BUSY, eb);
            end
        end
    endtask

    // Two LOADs back to back (last wins), then a lone SYNC applies the pending set at once.
    task automatic test_back_to_back();
        cfg_t         oldc[N];
        cfg_t         newc[N];
        logic [N-1:0] e, got;
        logic         eb;
        sync_load();
        for (int i = 0; i < N; i++) oldc[i] = drv[i];
        newc = oldc;
        newc[0].left  = 6;
        newc[0].right = 9;
        for (int j = 0; j < 26; j++) begin
            for (int i = 0; i < N; i++) e[i] = (j >= 6) ? hit(newc[i], j - 6) : hit(oldc[i], j);
            exp_pwm_q.push_back(e);
            exp_busy_q.push_back(j >= 2 && j <= 4);
            if (j == 2) begin
                drv[0].left  = 1;
                drv[0].right = 2;
                drive_cfg();
                bus.LOAD = 1'b1;
            end
            if (j == 3) begin
                drv = newc;
                drive_cfg();
                bus.LOAD = 1'b1;
            end
            if (j == 5) bus.SYNC = 1'b1;
            @(posedge CLK); #1;
            bus.LOAD = 1'b0;
            bus.SYNC = 1'b0;
            e   = exp_pwm_q.pop_front();
            eb  = exp_busy_q.pop_front();
            got = bus.PWM_OUT;
            checks++;
            if (got !== e || bus.BUSY !== eb) begin
                failures++;
                $display("FAIL back_to_back j=%0d pwm got=%b exp=%b busy got=%b exp=%b",
                         j, got, e, bus.BUSY, eb);
            end
        end
    endtask

`ifdef PWM_FORCE_OFF_EN
    task automatic test_force_off();
        logic [N-1:0] e, got;
        logic         f;
        drv[0] = '{cyc: 10, over: 1'b0, left: 3, right: 7};
        sync_load();
        for (int j = 0; j < 30; j++) begin
            f = (j >= 4 && j < 16);
            bus.FORCE_OFF = f;
            for (int i = 0; i < N; i++) e[i] = f ? 1'b0 : hit(drv[i], j);
            exp_pwm_q.push_back(e);
            @(posedge CLK); #1;
            e   = exp_pwm_q.pop_front();
            got = bus.PWM_OUT;
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL force_off j=%0d pwm got=%b exp=%b", j, got, e);
            end
        end
        bus.FORCE_OFF = 1'b0;
    endtask
`endif

    initial begin
        RST      = 1'b1;
        bus.SYNC = 1'b0;
        bus.LOAD = 1'b0;
`ifdef PWM_FORCE_OFF_EN
        bus.FORCE_OFF = 1'b0;
`endif
        for (int i = 0; i < N; i++) drv[i] = '0;
        drive_cfg();
        test_reset();
        test_basic();
        test_pending();
        test_back_to_back();
`ifdef PWM_FORCE_OFF_EN
        test_force_off();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
